// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multi-digit seven-segment scanning driver.
// Holds a frame of 5-bit digit codes and time-multiplexes the shared
// active-low cathode bus across NUM_DIGITS active-low anodes. New frames are
// swapped in only at the frame wrap, so a frame is never shown half old and
// half new. Also provides leading-zero blanking, per-digit decimal points and
// a short all-anodes-off gap at each slot start to suppress ghosting.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [5*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp_en,
    input  logic                      load,
    input  logic                      lzb_en,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_done
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [4:0]       CODE_BLANK = 5'd16;

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             boundary;

    // Displayed frame and the staged frame waiting for the next wrap.
    logic [4:0]            active_code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] active_dp;
    logic [4:0]            pend_code   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] pend_dp;
    logic                  pend_v;

    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;
    logic                  dp_next;

    function automatic logic [6:0] decode_seg(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'd0:    s = 7'b0000001;
            5'd1:    s = 7'b1001111;
            5'd2:    s = 7'b0010010;
            5'd3:    s = 7'b0000110;
            5'd4:    s = 7'b1001100;
            5'd5:    s = 7'b0100100;
            5'd6:    s = 7'b0100000;
            5'd7:    s = 7'b0001111;
            5'd8:    s = 7'b0000000;
            5'd9:    s = 7'b0000100;
            5'd10:   s = 7'b0001000;
            5'd11:   s = 7'b1100000;
            5'd12:   s = 7'b0110001;
            5'd13:   s = 7'b1000010;
            5'd14:   s = 7'b0110000;
            5'd15:   s = 7'b0111000;
            5'd17:   s = 7'b1111110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign boundary = (idx == IDX_LAST) && (cnt == CNT_LAST);

    // Slot timer and digit index; idx steps at the end of every slot.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame-synchronous update: loads are staged and promoted only at the wrap.
    // NOTE: the code storage is reset explicitly because the display must come
    // up blank, not with whatever the flops power up holding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_code[i] <= CODE_BLANK;
                pend_code[i]   <= CODE_BLANK;
            end
            active_dp <= '0;
            pend_dp   <= '0;
            pend_v    <= 1'b0;
        end else if (boundary && load) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                active_code[i] <= digits[5*i +: 5];
            active_dp <= dp_en;
            pend_v    <= 1'b0;
        end else if (boundary && pend_v) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                active_code[i] <= pend_code[i];
            active_dp <= pend_dp;
            pend_v    <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                pend_code[i] <= digits[5*i +: 5];
            pend_dp <= dp_en;
            pend_v  <= 1'b1;
        end
    end

    // Leading-zero mask: blank from the top digit down until a non-zero code.
    // NOTE: every combinational output is given a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        blank_mask = '0;
        zero_run   = lzb_en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (zero_run && (active_code[i] == 5'd0))
                blank_mask[i] = 1'b1;
            else
                zero_run = 1'b0;
        end
    end

    // Next-cycle pin values for the digit currently being scanned.
    always_comb begin
        an_next  = '1;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        if (cnt >= BLANK_C)
            an_next = ~(NUM_DIGITS'(1) << idx);
        if (!blank_mask[idx]) begin
            seg_next = decode_seg(active_code[idx]);
            dp_next  = ~active_dp[idx];
        end
    end

    // Registered pin drivers so the board sees glitch-free anode/cathode lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_done <= boundary;
        end
    end

endmodule
